// File: rtl/tank_input_ctrl.sv
// Turns raw direction/fire buttons into one direction command + fire request per frame_tick rise.
// Latency: strobe 1 cycle after the frame_tick rise; a press settles 2+DEBOUNCE_CYCLES cycles after the pin
// (3 cycles when TANK_INPUT_DEBOUNCE_EN is undefined). No backpressure: the strobe is fire-and-forget.
module tank_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_fire,
  input  logic       frame_tick,
  output logic [2:0] direction_cmd,
  output logic       valid_take_direction,
  output logic       fire_req
);

  localparam logic [4:0] REL_LVL  = (BTN_ACTIVE_LOW != 0) ? 5'h1f : 5'h00;
  localparam logic [2:0] DIR_NONE = 3'd4;

  // Bit order {fire, right, left, down, up} so bit index equals the direction code.
  logic [4:0] sync1_q, sync2_q, pressed;
  logic [4:0] deb_q, deb_d, press_edge;
  logic [2:0] latest_q, latest_d;
  logic       fire_pend_q, fire_pend_d;
  logic       tick_q, rise;
  logic [2:0] dir_q, dir_d;
  logic       vld_q, vld_d;
  logic       fire_q, fire_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
    end else begin
      sync1_q <= {btn_fire, btn_right, btn_left, btn_down, btn_up};
      sync2_q <= sync1_q;
    end
  end

  assign pressed = sync2_q ^ REL_LVL;

`ifdef TANK_INPUT_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [5];
  logic [CNT_W-1:0] cnt_d [5];

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = '0;
      if (pressed[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) deb_d[i] = ~deb_q[i];
        else                      cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '{default: '0};
    else        cnt_q <= cnt_d;
  end
`else
  // DEBOUNCE_CYCLES has no effect without the debounce counters.
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign deb_d = pressed;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) deb_q <= '0;
    else        deb_q <= deb_d;
  end

  function automatic logic [2:0] first_dir(input logic [3:0] v);
    if (v[0])      return 3'd0;
    else if (v[1]) return 3'd1;
    else if (v[2]) return 3'd2;
    else if (v[3]) return 3'd3;
    else           return DIR_NONE;
  endfunction

  // A new press always wins; otherwise fall back to the best held direction once the latest is released.
  always_comb begin
    press_edge = deb_d & ~deb_q;
    latest_d   = latest_q;
    if (|press_edge[3:0])
      latest_d = first_dir(press_edge[3:0]);
    else if (latest_q != DIR_NONE && !deb_d[latest_q[1:0]])
      latest_d = first_dir(deb_d[3:0]);
  end

  assign rise = frame_tick & ~tick_q;

  // A fire press landing in the sample cycle is folded into this frame's request.
  always_comb begin
    fire_pend_d = fire_pend_q | press_edge[4];
    vld_d       = rise;
    dir_d       = dir_q;
    fire_d      = 1'b0;
    if (rise) begin
      dir_d       = latest_d;
      fire_d      = fire_pend_d;
      fire_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latest_q    <= DIR_NONE;
      fire_pend_q <= 1'b0;
      tick_q      <= 1'b0;
      dir_q       <= DIR_NONE;
      vld_q       <= 1'b0;
      fire_q      <= 1'b0;
    end else begin
      latest_q    <= latest_d;
      fire_pend_q <= fire_pend_d;
      tick_q      <= frame_tick;
      dir_q       <= dir_d;
      vld_q       <= vld_d;
      fire_q      <= fire_d;
    end
  end

  assign direction_cmd        = dir_q;
  assign valid_take_direction = vld_q;
  assign fire_req             = fire_q;

endmodule

// File: tb/tb_tank_input_ctrl.sv
// Bench for tank_input_ctrl: directed scenarios plus random buttons/ticks against a per-frame scoreboard.
module tb_tank_input_ctrl;

  localparam int D  = 4;
  localparam int HL = D + 2;
`ifdef TANK_INPUT_DEBOUNCE_EN
  localparam bit DB_ON = 1'b1;
  localparam int LAT   = 2 + D;
`else
  localparam bit DB_ON = 1'b0;
  localparam int LAT   = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] pin_n;
  logic       frame_tick;
  logic [2:0] direction_cmd;
  logic       valid_take_direction;
  logic       fire_req;

  always #5 clk = ~clk;

  tank_input_ctrl #(.DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .btn_up               (pin_n[0]),
    .btn_down             (pin_n[1]),
    .btn_left             (pin_n[2]),
    .btn_right            (pin_n[3]),
    .btn_fire             (pin_n[4]),
    .frame_tick           (frame_tick),
    .direction_cmd        (direction_cmd),
    .valid_take_direction (valid_take_direction),
    .fire_req             (fire_req)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (per clock edge) ----------------
  typedef struct packed { logic [2:0] dir; logic fire; } exp_t;
  exp_t sb[$];

  bit [HL-1:0] hist [5];   // hist[b][j] = pressed level of button b, j edges ago
  bit [4:0]    m_deb;
  bit [2:0]    m_latest;
  bit          m_fire_pend;
  bit          m_tick_prev;

  always @(posedge clk) begin
    bit [4:0] p, nd, pe;
    bit       all_diff, fire_now;
    if (!rst_n) begin
      for (int b = 0; b < 5; b++) hist[b] = '0;
      m_deb = '0; m_latest = 3'd4; m_fire_pend = 1'b0; m_tick_prev = 1'b0;
      sb.delete();
    end else begin
      p = ~pin_n;
      for (int b = 0; b < 5; b++) begin
        hist[b] = {hist[b][HL-2:0], p[b]};
        if (DB_ON) begin
          // flips once the synchronized level has disagreed for D consecutive samples
          all_diff = 1'b1;
          for (int j = 2; j <= D + 1; j++) if (hist[b][j] == m_deb[b]) all_diff = 1'b0;
          nd[b] = all_diff ? ~m_deb[b] : m_deb[b];
        end else begin
          nd[b] = hist[b][2];
        end
      end
      pe = nd & ~m_deb;
      if (pe[3:0] != 4'b0) begin
        for (int d = 0; d < 4; d++) if (pe[d]) begin m_latest = 3'(d); break; end
      end else if (m_latest != 3'd4 && !nd[m_latest]) begin
        m_latest = 3'd4;
        for (int d = 0; d < 4; d++) if (nd[d]) begin m_latest = 3'(d); break; end
      end
      fire_now = m_fire_pend | pe[4];
      if (frame_tick && !m_tick_prev) begin
        sb.push_back('{dir: m_latest, fire: fire_now});
        m_fire_pend = 1'b0;
      end else begin
        m_fire_pend = fire_now;
      end
      m_tick_prev = frame_tick;
      m_deb = nd;
    end
  end

  // ---------------- monitor ----------------
  logic [2:0] hold_dir = 3'd4;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_dir", direction_cmd, 3'd4);
      chk("rst_vld", valid_take_direction, 1'b0);
      chk("rst_fire", fire_req, 1'b0);
      hold_dir = 3'd4;
    end else if (valid_take_direction) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe: got strobe, expected none at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("strobe_dir", direction_cmd, e.dir);
        chk("strobe_fire", fire_req, e.fire);
        hold_dir = e.dir;
      end
    end else begin
      if (sb.size() != 0) begin
        chk("missing_strobe", 32'd0, 32'd1);
        void'(sb.pop_front());
      end
      chk("idle_fire", fire_req, 1'b0);
      chk("hold_dir", direction_cmd, hold_dir);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_chk(input string nm, input logic [2:0] ed, input logic ef);
    frame_tick = 1'b1;
    step(1);
    chk({nm, "_vld"}, valid_take_direction, 1'b1);
    chk({nm, "_dir"}, direction_cmd, ed);
    chk({nm, "_fire"}, fire_req, ef);
    frame_tick = 1'b0;
    step(1);
  endtask

  initial begin
    int cnt, first;
    rst_n = 1'b0; pin_n = 5'h1f; frame_tick = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);
    tick_chk("reset_frame", 3'd4, 1'b0);

    // 3-cycle glitch on LEFT, then a held LEFT press
    pin_n[2] = 1'b0; step(3); pin_n[2] = 1'b1; step(10);
    tick_chk("after_glitch", 3'd4, 1'b0);
    pin_n[2] = 1'b0; step(6);
    tick_chk("left_held", 3'd2, 1'b0);
    pin_n[2] = 1'b1; step(12);

    // most recent press wins; release falls back to the still-held direction
    pin_n[0] = 1'b0; step(10);
    pin_n[3] = 1'b0; step(10);
    tick_chk("up_then_right", 3'd3, 1'b0);
    pin_n[3] = 1'b1; step(10);
    tick_chk("right_released", 3'd0, 1'b0);
    pin_n[0] = 1'b1; step(10);
    tick_chk("all_released", 3'd4, 1'b0);

    // fire latched between ticks, reported once
    pin_n[4] = 1'b0; step(8); pin_n[4] = 1'b1; step(8);
    tick_chk("fire_once", 3'd4, 1'b1);
    step(3);
    tick_chk("fire_cleared", 3'd4, 1'b0);

    // frame_tick held high: one strobe, in the first cycle after the rise
    cnt = 0; first = -1;
    frame_tick = 1'b1;
    for (int i = 0; i < 22; i++) begin
      step(1);
      if (valid_take_direction) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    frame_tick = 1'b0; step(2);
    chk("held_tick_count", cnt, 1);
    chk("held_tick_pos", first, 0);

    // reset while DOWN held and fire pending
    pin_n[1] = 1'b0; step(10);
    pin_n[4] = 1'b0; step(8); pin_n[4] = 1'b1; step(2);
    rst_n = 1'b0; #1;
    chk("midrst_dir", direction_cmd, 3'd4);
    chk("midrst_vld", valid_take_direction, 1'b0);
    chk("midrst_fire", fire_req, 1'b0);
    step(3);
    rst_n = 1'b1;
    tick_chk("post_rst_redebounce", 3'd4, 1'b0);
    step(10);
    tick_chk("post_rst_down", 3'd1, 1'b0);
    pin_n[1] = 1'b1; step(12);

    // press latency boundary: sampled one edge before / exactly at the debounced flip
    pin_n[0] = 1'b0; step(LAT - 2);
    tick_chk("lat_early", 3'd4, 1'b0);
    pin_n[0] = 1'b1; step(12);
    tick_chk("lat_idle", 3'd4, 1'b0);
    pin_n[0] = 1'b0; step(LAT - 1);
    tick_chk("lat_exact", 3'd0, 1'b0);
    pin_n[0] = 1'b1; step(12);

    // random buttons, ticks and occasional resets
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 9) == 0) pin_n[b] = ~pin_n[b];
      if ($urandom_range(0, 2) == 0) frame_tick = ~frame_tick;
      if ($urandom_range(0, 1499) == 0) begin
        rst_n = 1'b0; step(2); rst_n = 1'b1;
      end
      step(1);
    end
    frame_tick = 1'b0;
    step(4);
    chk("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tank_input_ctrl.md
# tank_input_ctrl

Player-side command generator feeding the tank block: it turns four raw direction buttons and a fire button into one frame-aligned direction command per frame, with a one-cycle `valid_take_direction` strobe. It sits between the board buttons and Game. Game forwards `direction_cmd` and `valid_take_direction` unchanged to the tank's `direction_in` and `valid_take_direction`. It synchronizes and debounces the buttons, tracks which held direction was pressed most recently, and latches fire presses until the next frame.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required before a debounced button changes (5 ms at 50 MHz); minimum 1.
- `BTN_ACTIVE_LOW`, default 1: 1 = a raw pin at 0 means pressed; 0 = a raw pin at 1 means pressed.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  raw, asynchronous direction buttons.
- `btn_fire`  in  1  raw, asynchronous fire button.
- `frame_tick`  in  1  frame marker from VGA; only its rising edge is used.
- `direction_cmd`  out  3  0 = UP, 1 = DOWN, 2 = LEFT, 3 = RIGHT, 4 = STAND; changes only in the strobe cycle.
- `valid_take_direction`  out  1  one-cycle strobe, once per frame.
- `fire_req`  out  1  high only in a strobe cycle, when a fire press is pending.

## Operation
- **Synchronizer:** each raw pin passes through a 2-flop synchronizer, then is normalized to active-high `pressed` according to `BTN_ACTIVE_LOW`.
- **Debounce:** there is one counter per button.
  - When the synchronized value differs from the debounced value, the counter increments; when they are equal, it clears.
  - When the count reaches `DEBOUNCE_CYCLES`, the debounced value flips and the counter clears.
- **Press edge:** a press edge is a 0→1 transition of a debounced direction or fire bit.
- **Latest-direction register:** holds 3 bits, with 4 meaning none.
  - On one or more direction press edges, it loads the pressed direction. If several press edges occur in the same cycle, priority is UP > DOWN > LEFT > RIGHT.
  - When the latest direction is released with no new press edge in the same cycle, it loads the highest-priority direction still held, or 4 if none is held.
  - A press edge and a release in the same cycle: the press edge wins.
  - Opposite directions held together are not special-cased; the most recent one wins.
- **Fire:** a fire press edge sets `fire_pending`.
- **Frame sample:** on the cycle after a `frame_tick` rising edge is detected:
  - `valid_take_direction` = 1;
  - `direction_cmd` = latest-direction register (4 when nothing is held);
  - `fire_req` = `fire_pending`, and `fire_pending` clears.
- **Fire coincident with the sample:** a fire press edge in the same cycle as the rising-edge detection is included in this frame's `fire_req`, and `fire_pending` ends cleared.
- **`frame_tick` held high:** holding `frame_tick` high for many cycles produces exactly one strobe.

## Timing
- **Reset values:** `direction_cmd` = 4 (STAND), `valid_take_direction` = 0, `fire_req` = 0.
- **Internal state at reset:** latest-direction = 4, `fire_pending` = 0, all counters 0, debounced bits = released, synchronizers = released, `frame_tick` edge register = 0.
- **Press latency:** a stable raw change becomes visible in the debounced bit 2 + `DEBOUNCE_CYCLES` cycles after the raw pin changes.
- **Glitch rejection:** a raw glitch shorter than `DEBOUNCE_CYCLES` cycles, after synchronization, produces no change.
- **Strobe latency:** `frame_tick` rises in cycle N (sampled at the edge ending cycle N) → strobe outputs are registered and valid in cycle N+1. Strobes are always at least 2 cycles apart.
- **Output stability:** `direction_cmd` holds its value between strobes. `fire_req` is 0 in every non-strobe cycle.
- **Reset during operation:** all state returns to the reset values immediately. A pending fire is lost, and buttons held through reset must re-debounce before taking effect.

## Configuration
- **`TANK_INPUT_DEBOUNCE_EN` defined:** debounce counters are implemented as described above.
- **`TANK_INPUT_DEBOUNCE_EN` undefined:**
  - counters are removed and `DEBOUNCE_CYCLES` is ignored;
  - each debounced bit equals its synchronized bit, registered once, so press latency is 3 cycles;
  - all other behaviour is unchanged.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4, `BTN_ACTIVE_LOW` = 1, with the macro defined unless stated otherwise.
- **Reset:** assert `rst_n` low with no buttons pressed, pulse `frame_tick` → strobe with `direction_cmd` = 4 and `fire_req` = 0.
- **Debounce and glitch:** drive `btn_left` low for 3 cycles then high; later hold it low, wait 6 cycles, pulse `frame_tick` → the glitch produces no change; the strobe carries `direction_cmd` = 2.
- **Latest-press priority:** hold UP, then press RIGHT 10 cycles later → next strobe carries 3; release RIGHT → following strobe carries 0; release all → strobe carries 4.
- **Fire latch:** press and release fire between two ticks → exactly one strobe has `fire_req` = 1; the following strobe has `fire_req` = 0.
- **`frame_tick` held:** hold `frame_tick` high for 20 cycles → exactly one `valid_take_direction` pulse, one cycle long, in the cycle after the rise.
- **Reset mid-operation and macro off:** assert `rst_n` while DOWN is held and fire is pending → outputs return to 4/0/0, and the first strobe after release shows `fire_req` = 0. With the macro undefined, a press becomes visible in the debounced bit after 3 cycles.
